lemming_ctrl: RTL and testbench
===============================

LEMMING_CTRL -- requirements
Module: lemming_ctrl

Interface
REQ-001 Parameter FALL_LIMIT, default 20: max cycles in a fall state that end safely on landing.
REQ-002 Parameter CNT_W, default 8: width of fall_count; SHALL be >= bits needed to hold FALL_LIMIT.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 areset_n  in  1  asynchronous, active-low reset.
REQ-005 bump_left  in  1  obstacle on left.
REQ-006 bump_right  in  1  obstacle on right.
REQ-007 ground  in  1  1 = ground present under lemming.
REQ-008 dig  in  1  request to start digging.
REQ-009 halt  in  1  request to stand still (new mode).
REQ-010 walk_left, walk_right, aaah, digging, halted, splat  out  1 each  Moore state decodes, one-hot or all-zero.
REQ-011 fall_count  out  CNT_W  cycles spent in current/last fall, saturating.

Function
REQ-012 States SHALL be WALK_L, WALK_R, FALL_L, FALL_R, DIG_L, DIG_R, HALT_L, HALT_R, SPLAT; the _L/_R suffix is the direction retained.
REQ-013 Outputs SHALL be Moore: walk_left=WALK_L, walk_right=WALK_R, aaah=FALL_*, digging=DIG_*, halted=HALT_*, splat=SPLAT.
REQ-014 Priority from WALK_x: ground=0 -> FALL_x; else dig=1 -> DIG_x; else halt=1 -> HALT_x; else bump toward current direction (or both) -> opposite WALK; else stay.
REQ-015 WALK_L with bump_left=1 -> WALK_R; WALK_R with bump_right=1 -> WALK_L; opposite-side bump ignored.
REQ-016 From HALT_x: ground=0 -> FALL_x; else dig=1 -> DIG_x; else halt=0 -> WALK_x; bumps ignored.
REQ-017 From DIG_x: ground=0 -> FALL_x; else stay; dig, halt, bumps ignored.
REQ-018 From FALL_x: ground=0 -> stay; ground=1 and fall_count >= FALL_LIMIT -> SPLAT; ground=1 otherwise -> WALK_x; bumps, dig, halt ignored.
REQ-019 SPLAT SHALL be absorbing: all six status outputs 0 except splat=1 until reset.
REQ-020 fall_count SHALL load 0 on every transition into FALL_x, increment by 1 each cycle spent in FALL_x with ground=0, saturate at 2^CNT_W-1, and hold its value in all other states.
REQ-021 Consequence: a fall lasting N cycles in FALL_x lands safely iff N <= FALL_LIMIT.
REQ-022 Simultaneous bump_left and bump_right while walking SHALL reverse direction exactly once.

Reset
REQ-023 areset_n=0 SHALL immediately (no clock) force WALK_L and fall_count=0: walk_left=1, all other status outputs 0.
REQ-024 Reset asserted mid-fall, mid-dig, in HALT or SPLAT SHALL abandon that state with no residual count.
REQ-025 First state update SHALL occur on the first rising clk edge after areset_n rises.

Structure
REQ-026 Shared package lemming_pkg SHALL hold the state encoding constants and the FALL_LIMIT default.
REQ-027 One sub-module sat_counter (parameter W; inputs clear, inc; output q) SHALL implement fall_count.
REQ-028 Next-state logic SHALL be a single combinational block; state and counter registers SHALL be separate sequential blocks.

Verification
REQ-029 Reset release, no inputs, ground=1 -> walk_left=1 held; bump_left=1 one cycle -> walk_right=1 next cycle.
REQ-030 Walking, ground=0 for 20 cycles then ground=1 -> aaah=1 for 20 cycles, fall_count=19, then same direction walk resumes.
REQ-031 Walking, ground=0 for 21 cycles then ground=1 -> splat=1 thereafter, ignoring all inputs; areset_n pulse -> walk_left=1.
REQ-032 WALK_R, dig=1 and bump_left=1 same cycle -> digging=1; ground=0 -> aaah=1; landing -> walk_right=1.
REQ-033 WALK_L, halt=1 for 5 cycles with bump_left=1 -> halted=1 for 5 cycles, then walk_left=1 resumes; ground=0 during halt -> aaah=1.
REQ-034 CNT_W=4, FALL_LIMIT=12, 30-cycle fall -> fall_count saturates at 15, landing -> splat=1.

Source files
------------

// File: rtl/lemming_pkg.sv
// Shared definitions for the lemming controller: state encoding and parameter defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lemming_pkg;

  // A fall longer than this many cycles ends in a splat.
  localparam int unsigned FALL_LIMIT_DEF = 20;
  localparam int          CNT_W_DEF      = 8;

  // The _L/_R suffix is the walking direction kept across fall/dig/halt.
  typedef enum logic [3:0] {
    WALK_L = 4'd0,
    WALK_R = 4'd1,
    FALL_L = 4'd2,
    FALL_R = 4'd3,
    DIG_L  = 4'd4,
    DIG_R  = 4'd5,
    HALT_L = 4'd6,
    HALT_R = 4'd7,
    SPLAT  = 4'd8
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over inc.
// Latency: q updates on the rising edge after clear/inc are sampled.
// Backpressure: none; holds at all-ones instead of wrapping.
// Ports: clk, areset_n (async active-low), clear, inc, q[W-1:0].
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         areset_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/lemming_ctrl.sv
// Lemming walker FSM: walk/fall/dig/halt/splat with a saturating fall-length counter.
// Latency: Moore outputs change one clock after the inputs that cause a transition.
// Backpressure: none; inputs sampled every cycle, SPLAT absorbs until reset.
// Ports: clk, areset_n; inputs bump_left, bump_right, ground, dig, halt;
//        outputs walk_left, walk_right, aaah, digging, halted, splat, fall_count[CNT_W-1:0].
module lemming_ctrl
  import lemming_pkg::*;
#(
  parameter int unsigned FALL_LIMIT = FALL_LIMIT_DEF,
  parameter int          CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             bump_left,
  input  logic             bump_right,
  input  logic             ground,
  input  logic             dig,
  input  logic             halt,
  output logic             walk_left,
  output logic             walk_right,
  output logic             aaah,
  output logic             digging,
  output logic             halted,
  output logic             splat,
  output logic [CNT_W-1:0] fall_count
);

  state_t state;
  state_t nxt;

  logic in_fall;
  logic nxt_fall;
  logic fall_clear;
  logic fall_inc;
  logic fall_over;

  assign in_fall  = (state == FALL_L) || (state == FALL_R);
  assign nxt_fall = (nxt == FALL_L) || (nxt == FALL_R);

  // Count restarts only on entry to a fall; a fall that continues keeps counting.
  assign fall_clear = !in_fall && nxt_fall;
  assign fall_inc   = in_fall && !ground;
  // The count excludes the first falling cycle, so >= LIMIT means LIMIT+1 cycles airborne.
  assign fall_over  = 32'(fall_count) >= FALL_LIMIT;

  // State register
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state <= WALK_L;
    end else begin
      state <= nxt;
    end
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      WALK_L: begin
        if (!ground)        nxt = FALL_L;
        else if (dig)       nxt = DIG_L;
        else if (halt)      nxt = HALT_L;
        else if (bump_left) nxt = WALK_R;
      end
      WALK_R: begin
        if (!ground)         nxt = FALL_R;
        else if (dig)        nxt = DIG_R;
        else if (halt)       nxt = HALT_R;
        else if (bump_right) nxt = WALK_L;
      end
      HALT_L: begin
        if (!ground)   nxt = FALL_L;
        else if (dig)  nxt = DIG_L;
        else if (!halt) nxt = WALK_L;
      end
      HALT_R: begin
        if (!ground)   nxt = FALL_R;
        else if (dig)  nxt = DIG_R;
        else if (!halt) nxt = WALK_R;
      end
      DIG_L:  if (!ground) nxt = FALL_L;
      DIG_R:  if (!ground) nxt = FALL_R;
      FALL_L: if (ground) nxt = fall_over ? SPLAT : WALK_L;
      FALL_R: if (ground) nxt = fall_over ? SPLAT : WALK_R;
      SPLAT:  nxt = SPLAT;
      default: nxt = WALK_L;
    endcase
  end

  // Moore output decode
  always_comb begin
    walk_left  = 1'b0;
    walk_right = 1'b0;
    aaah       = 1'b0;
    digging    = 1'b0;
    halted     = 1'b0;
    splat      = 1'b0;
    case (state)
      WALK_L:         walk_left  = 1'b1;
      WALK_R:         walk_right = 1'b1;
      FALL_L, FALL_R: aaah       = 1'b1;
      DIG_L, DIG_R:   digging    = 1'b1;
      HALT_L, HALT_R: halted     = 1'b1;
      SPLAT:          splat      = 1'b1;
      default:        ;
    endcase
  end

  sat_counter #(
    .W(CNT_W)
  ) u_fall_cnt (
    .clk      (clk),
    .areset_n (areset_n),
    .clear    (fall_clear),
    .inc      (fall_inc),
    .q        (fall_count)
  );

endmodule

// File: tb/tb_lemming_ctrl.sv
// Bench for lemming_ctrl: two instances (default and CNT_W=4/FALL_LIMIT=12) driven
// with the same stimulus, checked every cycle against a mode/direction reference
// model, plus literal checks of the key scenarios.
module tb_lemming_ctrl;

  logic clk;
  logic areset_n;
  logic bump_left, bump_right, ground, dig, halt;

  logic wl1, wr1, aa1, dg1, ha1, sp1;
  logic [7:0] fc1;
  logic wl2, wr2, aa2, dg2, ha2, sp2;
  logic [3:0] fc2;

  lemming_ctrl u_dut1 (
    .clk(clk), .areset_n(areset_n),
    .bump_left(bump_left), .bump_right(bump_right), .ground(ground), .dig(dig), .halt(halt),
    .walk_left(wl1), .walk_right(wr1), .aaah(aa1), .digging(dg1), .halted(ha1), .splat(sp1),
    .fall_count(fc1)
  );

  lemming_ctrl #(.FALL_LIMIT(12), .CNT_W(4)) u_dut2 (
    .clk(clk), .areset_n(areset_n),
    .bump_left(bump_left), .bump_right(bump_right), .ground(ground), .dig(dig), .halt(halt),
    .walk_left(wl2), .walk_right(wr2), .aaah(aa2), .digging(dg2), .halted(ha2), .splat(sp2),
    .fall_count(fc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  localparam int M_WALK = 0, M_FALL = 1, M_DIG = 2, M_HALT = 3, M_SPLAT = 4;
  int m_mode[2];
  bit m_right[2];
  int m_cnt[2];
  int m_lim[2] = '{20, 12};
  int m_max[2] = '{255, 15};

  task automatic model_step(input int i);
    bit bump_ahead;
    bump_ahead = m_right[i] ? bump_right : bump_left;
    case (m_mode[i])
      M_WALK: begin
        if (!ground)         begin m_mode[i] = M_FALL; m_cnt[i] = 0; end
        else if (dig)        m_mode[i] = M_DIG;
        else if (halt)       m_mode[i] = M_HALT;
        else if (bump_ahead) m_right[i] = !m_right[i];
      end
      M_HALT: begin
        if (!ground)   begin m_mode[i] = M_FALL; m_cnt[i] = 0; end
        else if (dig)  m_mode[i] = M_DIG;
        else if (!halt) m_mode[i] = M_WALK;
      end
      M_DIG: if (!ground) begin m_mode[i] = M_FALL; m_cnt[i] = 0; end
      M_FALL: begin
        if (!ground) m_cnt[i] = (m_cnt[i] < m_max[i]) ? m_cnt[i] + 1 : m_max[i];
        else if (m_cnt[i] >= m_lim[i]) m_mode[i] = M_SPLAT;
        else m_mode[i] = M_WALK;
      end
      default: ;
    endcase
  endtask

  always @(posedge clk or negedge areset_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!areset_n) begin
        m_mode[i] = M_WALK; m_right[i] = 1'b0; m_cnt[i] = 0;
      end else begin
        model_step(i);
      end
    end
  end

  function automatic logic [13:0] exp_vec(input int i);
    logic [5:0] st;
    st = {m_mode[i] == M_WALK && !m_right[i], m_mode[i] == M_WALK && m_right[i],
          m_mode[i] == M_FALL, m_mode[i] == M_DIG, m_mode[i] == M_HALT, m_mode[i] == M_SPLAT};
    return {st, 8'(m_cnt[i])};
  endfunction

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cycle_dut1", 32'({wl1, wr1, aa1, dg1, ha1, sp1, fc1}), 32'(exp_vec(0)));
      chk("cycle_dut2", 32'({wl2, wr2, aa2, dg2, ha2, sp2, 4'b0, fc2}), 32'(exp_vec(1)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input bit g, input bit bl, input bit br, input bit d, input bit h);
    ground = g; bump_left = bl; bump_right = br; dig = d; halt = h;
  endtask

  task automatic rst_pulse();
    areset_n = 1'b0;
    tick();
    areset_n = 1'b1;
  endtask

  int n;
  int gleft;

  initial begin
    areset_n = 1'b0;
    set_in(1, 0, 0, 0, 0);
    #1;
    chk("reset_status", 32'({wl1, wr1, aa1, dg1, ha1, sp1}), 32'b100000);
    chk("reset_count", 32'(fc1), 32'd0);
    tick(); tick();
    areset_n = 1'b1;
    cmp_en = 1'b1;

    // Idle walk left, then a single left bump turns right.
    repeat (3) tick();
    chk("idle_walk_left", 32'(wl1), 32'd1);
    set_in(1, 1, 0, 0, 0); tick();
    set_in(1, 0, 0, 0, 0);
    chk("bump_left_turns", 32'({wl1, wr1}), 32'b01);

    // 20-cycle fall lands safely and keeps direction.
    set_in(0, 0, 0, 0, 0);
    n = 0;
    repeat (20) begin tick(); if (aa1) n++; end
    chk("fall20_aaah_cycles", 32'(n), 32'd20);
    chk("fall20_count", 32'(fc1), 32'd19);
    set_in(1, 0, 0, 0, 0); tick();
    chk("fall20_lands_right", 32'(wr1), 32'd1);
    chk("count_holds_after_land", 32'(fc1), 32'd19);

    // 21-cycle fall splats; splat ignores inputs; async reset recovers.
    rst_pulse();
    set_in(0, 0, 0, 0, 0);
    repeat (21) tick();
    set_in(1, 0, 0, 0, 0); tick();
    chk("fall21_splat", 32'({wl1, wr1, aa1, dg1, ha1, sp1}), 32'b000001);
    repeat (8) begin
      set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    chk("splat_absorbing", 32'({wl1, wr1, aa1, dg1, ha1, sp1}), 32'b000001);
    set_in(1, 0, 0, 0, 0);
    areset_n = 1'b0;
    #1;
    chk("async_reset_from_splat", 32'({wl1, wr1, aa1, dg1, ha1, sp1}), 32'b100000);
    chk("async_reset_count", 32'(fc1), 32'd0);
    @(posedge clk); #2;
    areset_n = 1'b1;

    // Both bumps reverse exactly once per cycle.
    set_in(1, 1, 1, 0, 0); tick();
    chk("both_bumps_1", 32'({wl1, wr1}), 32'b01);
    tick();
    chk("both_bumps_2", 32'({wl1, wr1}), 32'b10);

    // Dig from WALK_R wins over a bump; fall from dig lands walking right.
    set_in(1, 1, 0, 0, 0); tick();
    set_in(1, 1, 0, 1, 0); tick();
    chk("dig_beats_bump", 32'(dg1), 32'd1);
    set_in(0, 0, 0, 0, 0); tick();
    chk("dig_then_fall", 32'(aa1), 32'd1);
    set_in(1, 0, 0, 0, 0); tick();
    chk("dig_fall_lands_right", 32'(wr1), 32'd1);

    // Halt for 5 cycles with a bump, resume left; fall out of halt.
    set_in(1, 0, 1, 0, 0); tick();
    set_in(1, 1, 0, 0, 1);
    n = 0;
    repeat (5) begin tick(); if (ha1) n++; end
    chk("halt5_cycles", 32'(n), 32'd5);
    set_in(1, 0, 0, 0, 0); tick();
    chk("halt_resume_left", 32'(wl1), 32'd1);
    set_in(1, 0, 0, 0, 1); tick();
    set_in(0, 0, 0, 0, 1); tick();
    chk("halt_then_fall", 32'(aa1), 32'd1);
    set_in(1, 0, 0, 0, 0); tick();
    chk("halt_fall_lands_left", 32'(wl1), 32'd1);

    // 30-cycle fall: narrow counter saturates at 15; both instances splat.
    rst_pulse();
    set_in(0, 0, 0, 0, 0);
    repeat (30) tick();
    chk("sat_count_w4", 32'(fc2), 32'd15);
    chk("count_w8_30fall", 32'(fc1), 32'd29);
    set_in(1, 0, 0, 0, 0); tick();
    chk("sat_land_splat_w4", 32'(sp2), 32'd1);
    chk("land_splat_w8", 32'(sp1), 32'd1);

    // Randomized phase with ground-loss bursts and occasional resets.
    rst_pulse();
    gleft = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        set_in(1, 0, 0, 0, 0);
        rst_pulse();
      end else begin
        if (gleft > 0) begin
          ground = 1'b0; gleft--;
        end else if ($urandom_range(0, 7) == 0) begin
          ground = 1'b0; gleft = $urandom_range(0, 24);
        end else begin
          ground = 1'b1;
        end
        bump_left  = ($urandom_range(0, 2) == 0);
        bump_right = ($urandom_range(0, 2) == 0);
        dig        = ($urandom_range(0, 15) == 0);
        halt       = ($urandom_range(0, 5) == 0);
        tick();
      end
    end

    @(negedge clk);
    cmp_en = 1'b0;
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
